// File: rtl/brownout_pkg.sv
// Shared types and defaults for the brown-out release sequencer.
// Holds the sequencer state encoding and the default settle gap.
package brownout_pkg;

    // seq_state debug encoding: IDLE=00, ARM=01, RELEASE=10, DONE=11
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARM     = 2'b01,
        RELEASE = 2'b10,
        DONE    = 2'b11
    } seq_state_t;

    localparam int GAP_CYC_DEF = 16;

endpackage

// File: rtl/brownout_gap_timer.sv
// Settle-gap timer: GAP_W-bit up-counter with synchronous clear.
// Ports: osc_ck clock, clr_cnt_sb async clear (active-low),
//        i_clr sync clear, o_expire high when count == GAP_CYC-1.
module brownout_gap_timer #(
    parameter int GAP_W   = 5,
    parameter int GAP_CYC = 16
) (
    input  logic osc_ck,
    input  logic clr_cnt_sb,
    input  logic i_clr,
    output logic o_expire
);

    localparam logic [GAP_W-1:0] LAST = GAP_W'(GAP_CYC - 1);

    logic [GAP_W-1:0] r_cnt;

    // Cleared on every release, so the count never wraps.
    always_ff @(posedge osc_ck or negedge clr_cnt_sb) begin
        if (!clr_cnt_sb) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = (r_cnt == LAST);

endmodule

// File: rtl/brownout_release_seq.sv
// Releases active-low domain resets one at a time after supply-good,
// with a GAP_CYC settle gap; any trip re-asserts all of them.
// Ports: osc_ck clock, clr_cnt_sb async clear (active-low), ena,
//        outb_unbuf supply-good, dcomp comparator trip,
//        rst_dom_b domain resets, seq_done, seq_state debug.
// Option: BROUT_SEQ_ABORT_CNT_EN adds abort_cnt[7:0].
module brownout_release_seq
    import brownout_pkg::*;
#(
    parameter int N_STAGES = 3,
    parameter int GAP_CYC  = GAP_CYC_DEF,
    parameter int GAP_W    = 5
) (
    input  logic                osc_ck,
    input  logic                clr_cnt_sb,
    input  logic                ena,
    input  logic                outb_unbuf,
    input  logic                dcomp,
    output logic [N_STAGES-1:0] rst_dom_b,
    output logic                seq_done,
    output logic [1:0]          seq_state
`ifdef BROUT_SEQ_ABORT_CNT_EN
    ,
    output logic [7:0]          abort_cnt
`endif
);

    localparam int IDX_W = $clog2(N_STAGES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STAGES - 1);

    seq_state_t          r_state;
    seq_state_t          w_state_nxt;
    logic [IDX_W-1:0]    r_stage_idx;
    logic [IDX_W-1:0]    w_stage_idx_nxt;
    logic [N_STAGES-1:0] r_rst_dom_b;
    logic [N_STAGES-1:0] w_rst_dom_b_nxt;
    logic                r_seq_done;
    logic                w_seq_done_nxt;
    logic                w_abort;
    logic                w_expire;
    logic                w_counting;
    logic                w_gap_clr;
    logic                w_last;

    // Abort has priority over every transition, including gap expiry.
    assign w_abort    = (r_state != IDLE) &&
                        (dcomp || !outb_unbuf || !ena);
    assign w_counting = (r_state == ARM) || (r_state == RELEASE);
    assign w_gap_clr  = !w_counting || w_abort || w_expire;
    assign w_last     = (r_stage_idx == LAST_IDX);

    brownout_gap_timer #(
        .GAP_W   (GAP_W),
        .GAP_CYC (GAP_CYC)
    ) u_gap (
        .osc_ck     (osc_ck),
        .clr_cnt_sb (clr_cnt_sb),
        .i_clr      (w_gap_clr),
        .o_expire   (w_expire)
    );

    always_ff @(posedge osc_ck or negedge clr_cnt_sb) begin
        if (!clr_cnt_sb) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (ena && outb_unbuf) w_state_nxt = ARM;
                end
                ARM, RELEASE: begin
                    if (w_expire && w_last) w_state_nxt = DONE;
                    else if (w_expire)      w_state_nxt = RELEASE;
                end
                DONE:    w_state_nxt = DONE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Next values for the registered outputs.
    always_comb begin
        w_rst_dom_b_nxt = r_rst_dom_b;
        w_seq_done_nxt  = r_seq_done;
        w_stage_idx_nxt = r_stage_idx;
        if (w_abort || (r_state == IDLE)) begin
            w_rst_dom_b_nxt = '0;
            w_seq_done_nxt  = 1'b0;
            w_stage_idx_nxt = '0;
        end else if (w_counting && w_expire) begin
            for (int i = 0; i < N_STAGES; i++) begin
                if (IDX_W'(i) == r_stage_idx) w_rst_dom_b_nxt[i] = 1'b1;
            end
            w_stage_idx_nxt = r_stage_idx + 1'b1;
            w_seq_done_nxt  = w_last;
        end
    end

    always_ff @(posedge osc_ck or negedge clr_cnt_sb) begin
        if (!clr_cnt_sb) begin
            r_rst_dom_b <= '0;
            r_seq_done  <= 1'b0;
            r_stage_idx <= '0;
        end else begin
            r_rst_dom_b <= w_rst_dom_b_nxt;
            r_seq_done  <= w_seq_done_nxt;
            r_stage_idx <= w_stage_idx_nxt;
        end
    end

    assign rst_dom_b = r_rst_dom_b;
    assign seq_done  = r_seq_done;
    assign seq_state = r_state;

`ifdef BROUT_SEQ_ABORT_CNT_EN
    logic [7:0] r_abort_cnt;

    // Saturating; only the async clear resets it.
    always_ff @(posedge osc_ck or negedge clr_cnt_sb) begin
        if (!clr_cnt_sb) begin
            r_abort_cnt <= '0;
        end else if (w_abort && (r_abort_cnt != 8'hFF)) begin
            r_abort_cnt <= r_abort_cnt + 8'd1;
        end
    end

    assign abort_cnt = r_abort_cnt;
`endif

endmodule

// File: tb/tb_brownout_release_seq.sv
// Directed self-checking bench for brownout_release_seq.
// Covers default build plus an N_STAGES=1/GAP_CYC=2 corner instance.
module tb_brownout_release_seq;

    logic       osc_ck = 1'b0;
    logic       clr_cnt_sb;
    logic       ena;
    logic       outb_unbuf;
    logic       dcomp;
    logic [2:0] rst_dom_b;
    logic       seq_done;
    logic [1:0] seq_state;
    logic [0:0] c_rst_dom_b;
    logic       c_seq_done;
    logic [1:0] c_seq_state;
`ifdef BROUT_SEQ_ABORT_CNT_EN
    logic [7:0] abort_cnt;
    logic [7:0] c_abort_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 osc_ck = ~osc_ck;

    brownout_release_seq #(
        .N_STAGES (3),
        .GAP_CYC  (16),
        .GAP_W    (5)
    ) dut (
        .osc_ck     (osc_ck),
        .clr_cnt_sb (clr_cnt_sb),
        .ena        (ena),
        .outb_unbuf (outb_unbuf),
        .dcomp      (dcomp),
        .rst_dom_b  (rst_dom_b),
        .seq_done   (seq_done),
        .seq_state  (seq_state)
`ifdef BROUT_SEQ_ABORT_CNT_EN
        ,
        .abort_cnt  (abort_cnt)
`endif
    );

    brownout_release_seq #(
        .N_STAGES (1),
        .GAP_CYC  (2),
        .GAP_W    (2)
    ) dut_c (
        .osc_ck     (osc_ck),
        .clr_cnt_sb (clr_cnt_sb),
        .ena        (ena),
        .outb_unbuf (outb_unbuf),
        .dcomp      (dcomp),
        .rst_dom_b  (c_rst_dom_b),
        .seq_done   (c_seq_done),
        .seq_state  (c_seq_state)
`ifdef BROUT_SEQ_ABORT_CNT_EN
        ,
        .abort_cnt  (c_abort_cnt)
`endif
    );

    // Advance one rising edge; sample/drive 1 time unit after it.
    task automatic tick();
        @(posedge osc_ck);
        #1;
    endtask

    task automatic do_reset();
        clr_cnt_sb = 1'b0;
        ena        = 1'b1;
        outb_unbuf = 1'b0;
        dcomp      = 1'b0;
        tick();
        tick();
        clr_cnt_sb = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clr_cnt_sb = 1'b0;
        ena        = 1'b0;
        outb_unbuf = 1'b0;
        dcomp      = 1'b0;
        #3;
        n_tests++;
        if (rst_dom_b !== 3'b000 || seq_done !== 1'b0 ||
            seq_state !== 2'b00) begin
            n_fail++;
            $display("FAIL reset: dom=%b done=%b st=%b, need 000 0 00",
                     rst_dom_b, seq_done, seq_state);
        end
        tick();
        clr_cnt_sb = 1'b1;
        tick();
        n_tests++;
        if (seq_state !== 2'b00 || rst_dom_b !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_ena0: st=%b dom=%b, need 00 000",
                     seq_state, rst_dom_b);
        end
    endtask

    task automatic test_nominal();
        do_reset();
        outb_unbuf = 1'b1;
        tick();
        n_tests++;
        if (seq_state !== 2'b01) begin
            n_fail++;
            $display("FAIL nom_arm: st=%b, need 01", seq_state);
        end
        repeat (15) tick();
        n_tests++;
        if (rst_dom_b !== 3'b000) begin
            n_fail++;
            $display("FAIL nom_c15: dom=%b, need 000", rst_dom_b);
        end
        tick();
        n_tests++;
        if (rst_dom_b !== 3'b001 || seq_state !== 2'b10) begin
            n_fail++;
            $display("FAIL nom_c16: dom=%b st=%b, need 001 10",
                     rst_dom_b, seq_state);
        end
        repeat (15) tick();
        n_tests++;
        if (rst_dom_b !== 3'b001) begin
            n_fail++;
            $display("FAIL nom_c31: dom=%b, need 001", rst_dom_b);
        end
        tick();
        n_tests++;
        if (rst_dom_b !== 3'b011 || seq_done !== 1'b0) begin
            n_fail++;
            $display("FAIL nom_c32: dom=%b done=%b, need 011 0",
                     rst_dom_b, seq_done);
        end
        repeat (15) tick();
        n_tests++;
        if (rst_dom_b !== 3'b011 || seq_done !== 1'b0) begin
            n_fail++;
            $display("FAIL nom_c47: dom=%b done=%b, need 011 0",
                     rst_dom_b, seq_done);
        end
        tick();
        n_tests++;
        if (rst_dom_b !== 3'b111 || seq_done !== 1'b1 ||
            seq_state !== 2'b11) begin
            n_fail++;
            $display("FAIL nom_c48: dom=%b done=%b st=%b, need 111 1 11",
                     rst_dom_b, seq_done, seq_state);
        end
        repeat (20) tick();
        n_tests++;
        if (rst_dom_b !== 3'b111 || seq_done !== 1'b1 ||
            seq_state !== 2'b11) begin
            n_fail++;
            $display("FAIL nom_hold: dom=%b done=%b st=%b, need 111 1 11",
                     rst_dom_b, seq_done, seq_state);
        end
    endtask

    task automatic test_ena_low();
        ena = 1'b0;
        tick();
        n_tests++;
        if (rst_dom_b !== 3'b000 || seq_done !== 1'b0 ||
            seq_state !== 2'b00) begin
            n_fail++;
            $display("FAIL ena_abort: dom=%b done=%b st=%b, need 000 0 00",
                     rst_dom_b, seq_done, seq_state);
        end
        ena = 1'b1;
    endtask

    task automatic test_trip();
        do_reset();
        outb_unbuf = 1'b1;
        tick();
        repeat (20) tick();
        n_tests++;
        if (rst_dom_b !== 3'b001) begin
            n_fail++;
            $display("FAIL trip_pre: dom=%b, need 001", rst_dom_b);
        end
        dcomp      = 1'b1;
        outb_unbuf = 1'b0;
        tick();
        dcomp = 1'b0;
        n_tests++;
        if (rst_dom_b !== 3'b000 || seq_state !== 2'b00) begin
            n_fail++;
            $display("FAIL trip_abort: dom=%b st=%b, need 000 00",
                     rst_dom_b, seq_state);
        end
        tick();
        outb_unbuf = 1'b1;
        tick();
        repeat (15) tick();
        n_tests++;
        if (rst_dom_b !== 3'b000) begin
            n_fail++;
            $display("FAIL trip_reseq15: dom=%b, need 000", rst_dom_b);
        end
        tick();
        n_tests++;
        if (rst_dom_b !== 3'b001) begin
            n_fail++;
            $display("FAIL trip_reseq16: dom=%b, need 001", rst_dom_b);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        outb_unbuf = 1'b1;
        tick();
        repeat (40) tick();
        n_tests++;
        if (rst_dom_b !== 3'b011) begin
            n_fail++;
            $display("FAIL ar_pre: dom=%b, need 011", rst_dom_b);
        end
        #2;
        clr_cnt_sb = 1'b0;
        #1;
        n_tests++;
        if (rst_dom_b !== 3'b000 || seq_done !== 1'b0 ||
            seq_state !== 2'b00) begin
            n_fail++;
            $display("FAIL ar_async: dom=%b done=%b st=%b, need 000 0 00",
                     rst_dom_b, seq_done, seq_state);
        end
        @(negedge osc_ck);
        clr_cnt_sb = 1'b1;
        tick();
        repeat (15) tick();
        n_tests++;
        if (rst_dom_b !== 3'b000) begin
            n_fail++;
            $display("FAIL ar_rel15: dom=%b, need 000", rst_dom_b);
        end
        tick();
        n_tests++;
        if (rst_dom_b !== 3'b001) begin
            n_fail++;
            $display("FAIL ar_rel16: dom=%b, need 001", rst_dom_b);
        end
    endtask

    task automatic test_simul_abort();
        do_reset();
        outb_unbuf = 1'b1;
        tick();
        repeat (15) tick();
        outb_unbuf = 1'b0;
        tick();
        n_tests++;
        if (rst_dom_b !== 3'b000 || seq_state !== 2'b00) begin
            n_fail++;
            $display("FAIL simul: dom=%b st=%b, need 000 00",
                     rst_dom_b, seq_state);
        end
        repeat (3) tick();
        n_tests++;
        if (rst_dom_b !== 3'b000 || seq_state !== 2'b00) begin
            n_fail++;
            $display("FAIL simul_hold: dom=%b st=%b, need 000 00",
                     rst_dom_b, seq_state);
        end
    endtask

    task automatic test_corner();
        do_reset();
        outb_unbuf = 1'b1;
        tick();
        tick();
        n_tests++;
        if (c_rst_dom_b !== 1'b0 || c_seq_done !== 1'b0) begin
            n_fail++;
            $display("FAIL corner_c1: dom=%b done=%b, need 0 0",
                     c_rst_dom_b, c_seq_done);
        end
        tick();
        n_tests++;
        if (c_rst_dom_b !== 1'b1 || c_seq_done !== 1'b1 ||
            c_seq_state !== 2'b11) begin
            n_fail++;
            $display("FAIL corner_c2: dom=%b done=%b st=%b, need 1 1 11",
                     c_rst_dom_b, c_seq_done, c_seq_state);
        end
    endtask

`ifdef BROUT_SEQ_ABORT_CNT_EN
    task automatic test_abort_cnt();
        do_reset();
        n_tests++;
        if (abort_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL acnt_init: cnt=%0d, need 0", abort_cnt);
        end
        dcomp = 1'b1;
        repeat (4) tick();
        dcomp = 1'b0;
        n_tests++;
        if (abort_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL acnt_idle: cnt=%0d, need 0", abort_cnt);
        end
        for (int i = 1; i <= 260; i++) begin
            outb_unbuf = 1'b1;
            tick();
            outb_unbuf = 1'b0;
            tick();
            if (i == 5) begin
                n_tests++;
                if (abort_cnt !== 8'd5) begin
                    n_fail++;
                    $display("FAIL acnt_5: cnt=%0d, need 5", abort_cnt);
                end
            end
        end
        n_tests++;
        if (abort_cnt !== 8'hFF) begin
            n_fail++;
            $display("FAIL acnt_sat: cnt=%h, need ff", abort_cnt);
        end
        #2;
        clr_cnt_sb = 1'b0;
        #1;
        n_tests++;
        if (abort_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL acnt_clr: cnt=%0d, need 0", abort_cnt);
        end
        clr_cnt_sb = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_ena_low();
        test_trip();
        test_async_reset();
        test_simul_abort();
        test_corner();
`ifdef BROUT_SEQ_ABORT_CNT_EN
        test_abort_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
